// File: rtl/pipeline_pkg.sv
// Shared constants for the write-back scheduling path.
package pipeline_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int REQ_ALU    = 0;
  localparam int REQ_MEM    = 1;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register file write port.
// The requester that did not win the last accepted handshake wins a tie.
module wb_rr_arbiter
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       handshake,
  output logic [1:0] grant
);

  logic last_grant;

  // Grant decision from the current requests and the previous winner.
  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant[REQ_ALU] = 1'b1;
      2'b10:   grant[REQ_MEM] = 1'b1;
      2'b11: begin
        if (last_grant == 1'(REQ_MEM)) grant[REQ_ALU] = 1'b1;
        else                           grant[REQ_MEM] = 1'b1;
      end
      default: grant = '0;
    endcase
  end

  // Remember the winner of each accepted handshake; reset favours ALU first.
  always_ff @(posedge clk) begin
    if (!rst_n)         last_grant <= 1'(REQ_MEM);
    else if (handshake) last_grant <= grant[REQ_MEM];
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register file write-port scheduler: round-robin write-back arbitration,
// a registered write stage, and a pending-write scoreboard that stalls decode.
module regfile_wb_sched
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic                 id_wr,
  input  logic [ADDR_W-1:0]    id_rs,
  input  logic [ADDR_W-1:0]    id_rt,
  input  logic [ADDR_W-1:0]    id_rd,
  output logic                 id_stall,
  input  logic                 wb0_valid,
  input  logic [ADDR_W-1:0]    wb0_rd,
  input  logic [DATA_W-1:0]    wb0_data,
  output logic                 wb0_ready,
  input  logic                 wb1_valid,
  input  logic [ADDR_W-1:0]    wb1_rd,
  input  logic [DATA_W-1:0]    wb1_data,
  output logic                 wb1_ready,
  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_rd,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 sb_err
);

  localparam int NREG = 2**ADDR_W;

  logic [1:0]        grant;
  logic              hs_p0;
  logic [ADDR_W-1:0] sel_rd_p0;
  logic [DATA_W-1:0] sel_data_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic [DATA_W-1:0] data_p1;
  logic [NREG-1:0]   pend_q;
  logic              err_q;
  logic              issue_set;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     ({wb1_valid, wb0_valid}),
    .handshake (hs_p0),
    .grant     (grant)
  );

  assign wb0_ready = grant[REQ_ALU];
  assign wb1_ready = grant[REQ_MEM];

  // Stage p0: select the granted request; a grant implies a valid request.
  always_comb begin
    hs_p0       = |grant;
    sel_rd_p0   = wb0_rd;
    sel_data_p0 = wb0_data;
    if (grant[REQ_MEM]) begin
      sel_rd_p0   = wb1_rd;
      sel_data_p0 = wb1_data;
    end
  end

  // Hazard check uses only registered pending bits; there is no bypass.
  always_comb begin
    id_stall  = id_valid & (pend_q[id_rs] | pend_q[id_rt] | (id_wr & pend_q[id_rd]));
    issue_set = id_valid & id_wr & ~id_stall;
  end

  // Stage p1: write port register; it always drains, so there is no back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= hs_p0;
      if (hs_p0) begin
        rd_p1   <= sel_rd_p0;
        data_p1 <= sel_data_p0;
      end
    end
  end

  // Scoreboard: clear on commit, then set on issue so a newer write stays pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      logic [NREG-1:0] nxt;
      nxt = pend_q;
      if (vld_p1)    nxt[rd_p1] = 1'b0;
      if (issue_set) nxt[id_rd] = 1'b1;
      pend_q <= nxt;
    end
  end

  // Sticky error when a write-back targets a register with no write in flight.
  always_ff @(posedge clk) begin
    if (!rst_n)                          err_q <= 1'b0;
    else if (hs_p0 && !pend_q[sel_rd_p0]) err_q <= 1'b1;
  end

  assign rf_write = vld_p1;
  assign rf_rd    = rd_p1;
  assign rf_wdata = data_p1;
  assign pending  = pend_q;
  assign sb_err   = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_wb_sched;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_wr;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_stall;
  logic          wb0_valid, wb1_valid;
  logic [AW-1:0] wb0_rd, wb1_rd;
  logic [DW-1:0] wb0_data, wb1_data;
  logic          wb0_ready, wb1_ready;
  logic          rf_write;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] pending;
  logic          sb_err;

  always #5 clk = ~clk;

  regfile_wb_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_wr(id_wr), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_stall(id_stall),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_write(rf_write), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pending(pending), .sb_err(sb_err)
  );

  // Behavioural model state
  logic [NR-1:0] m_pend;
  int            m_lg;
  logic          m_rfw;
  logic [AW-1:0] m_rfrd;
  logic [DW-1:0] m_rfdata;
  logic          m_err;
  logic          m_known;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester should win this cycle (-1 when none).
  function automatic int winner();
    if (wb0_valid && wb1_valid) return (m_lg == 0) ? 1 : 0;
    if (wb0_valid) return 0;
    if (wb1_valid) return 1;
    return -1;
  endfunction

  // Compare all outputs against the model, advance the model, then cross one edge.
  task automatic step();
    int            w;
    logic          exp_stall;
    logic [NR-1:0] np;
    logic [AW-1:0] wrd;
    #2;
    w = winner();
    exp_stall = id_valid && (m_pend[id_rs] || m_pend[id_rt] || (id_wr && m_pend[id_rd]));
    if (m_known) begin
      chk("id_stall",  64'(id_stall),  64'(exp_stall));
      chk("wb0_ready", 64'(wb0_ready), 64'(w == 0));
      chk("wb1_ready", 64'(wb1_ready), 64'(w == 1));
      chk("rf_write",  64'(rf_write),  64'(m_rfw));
      chk("rf_rd",     64'(rf_rd),     64'(m_rfrd));
      chk("rf_wdata",  64'(rf_wdata),  64'(m_rfdata));
      chk("pending",   64'(pending),   64'(m_pend));
      chk("sb_err",    64'(sb_err),    64'(m_err));
    end
    if (!rst_n) begin
      m_pend = '0; m_lg = 1; m_rfw = 1'b0; m_rfrd = '0; m_rfdata = '0; m_err = 1'b0;
      m_known = 1'b1;
    end else begin
      np = m_pend;
      if (m_rfw) np[m_rfrd] = 1'b0;
      if (id_valid && id_wr && !exp_stall) np[id_rd] = 1'b1;
      if (w >= 0) begin
        wrd = (w == 0) ? wb0_rd : wb1_rd;
        if (!m_pend[wrd]) m_err = 1'b1;
        m_rfrd   = wrd;
        m_rfdata = (w == 0) ? wb0_data : wb1_data;
        m_rfw    = 1'b1;
        m_lg     = w;
      end else begin
        m_rfw = 1'b0;
      end
      m_pend = np;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    id_valid = 1'b1; id_wr = 1'b1; id_rd = rd; id_rs = '0; id_rt = '0;
    step();
    id_valid = 1'b0; id_wr = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_rd();
    if (m_pend != '0 && ($urandom % 4) != 0) begin
      for (int k = 0; k < 64; k++) begin
        logic [AW-1:0] c;
        c = AW'($urandom);
        if (m_pend[c]) return c;
      end
    end
    return AW'($urandom);
  endfunction

  initial begin
    m_known = 1'b0;
    m_pend = '0; m_lg = 1; m_rfw = 1'b0; m_rfrd = '0; m_rfdata = '0; m_err = 1'b0;
    rst_n = 1'b0; id_valid = 1'b0; id_wr = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    @(posedge clk); #1;

    // Reset held for two cycles
    step(); step();
    chk("rst_rf_write", 64'(rf_write), 64'd0);
    chk("rst_rf_rd",    64'(rf_rd),    64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_pending",  64'(pending),  64'd0);
    chk("rst_sb_err",   64'(sb_err),   64'd0);
    rst_n = 1'b1;

    // Single write through MEM
    issue(4'd5);
    chk("pend5_set", 64'(pending), 64'h0020);
    wb1_valid = 1'b1; wb1_rd = 4'd5; wb1_data = 32'hDEADBEEF;
    #1 chk("wb1_ready_single", 64'(wb1_ready), 64'd1);
    step();
    wb1_valid = 1'b0;
    chk("single_rf_write", 64'(rf_write), 64'd1);
    chk("single_rf_rd",    64'(rf_rd),    64'd5);
    chk("single_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    step();
    chk("pend5_clear", 64'(pending), 64'd0);

    // Round-robin: ALU then MEM
    issue(4'd3); issue(4'd4);
    wb0_valid = 1'b1; wb0_rd = 4'd3; wb0_data = 32'h1111_0003;
    wb1_valid = 1'b1; wb1_rd = 4'd4; wb1_data = 32'h2222_0004;
    #1 chk("rr_alu_first", 64'({wb1_ready, wb0_ready}), 64'b01);
    step();
    chk("rr_rd_a", 64'(rf_rd), 64'd3);
    wb0_valid = 1'b0;
    step();
    chk("rr_rd_b", 64'(rf_rd), 64'd4);
    wb1_valid = 1'b0;
    issue(4'd3); issue(4'd4);
    wb0_valid = 1'b1; wb1_valid = 1'b1;
    step();
    chk("rr2_rd_a", 64'(rf_rd), 64'd3);
    step();
    chk("rr2_rd_b", 64'(rf_rd), 64'd4);
    chk("rr2_data_b", 64'(rf_wdata), 64'h2222_0004);
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    step();

    // RAW stall on r7
    issue(4'd7);
    id_valid = 1'b1; id_wr = 1'b0; id_rs = 4'd7; id_rt = 4'd0;
    #1 chk("raw_stall_n", 64'(id_stall), 64'd1);
    wb0_valid = 1'b1; wb0_rd = 4'd7; wb0_data = 32'h7777_7777;
    step();
    wb0_valid = 1'b0;
    chk("raw_stall_n1", 64'(id_stall), 64'd1);
    step();
    chk("raw_stall_n2", 64'(id_stall), 64'd0);
    id_valid = 1'b0;
    step();

    // sb_err on a write-back to non-pending r9; write still issued
    wb0_valid = 1'b1; wb0_rd = 4'd9; wb0_data = 32'h9999_0009;
    step();
    wb0_valid = 1'b0;
    chk("err_set",   64'(sb_err),   64'd1);
    chk("err_write", 64'(rf_write), 64'd1);
    chk("err_rd",    64'(rf_rd),    64'd9);

    // Same-edge set and clear of r2
    wb1_valid = 1'b1; wb1_rd = 4'd2; wb1_data = 32'h0000_0002;
    step();
    wb1_valid = 1'b0;
    issue(4'd2);
    chk("setclr_pend2", 64'(pending[2]), 64'd1);
    chk("err_sticky",   64'(sb_err),     64'd1);

    // Reset while a write sits in the output stage
    issue(4'd6);
    wb0_valid = 1'b1; wb0_rd = 4'd6; wb0_data = 32'h6666_0006;
    step();
    wb0_valid = 1'b0;
    chk("midrst_pre", 64'(rf_write), 64'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_write", 64'(rf_write), 64'd0);
    chk("midrst_pend",  64'(pending),  64'd0);
    chk("midrst_err",   64'(sb_err),   64'd0);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst_n    = ($urandom_range(0, 149) != 0);
      id_valid = $urandom_range(0, 1) == 1;
      id_wr    = $urandom_range(0, 3) != 0;
      id_rs    = AW'($urandom);
      id_rt    = AW'($urandom);
      id_rd    = AW'($urandom);
      wb0_valid = $urandom_range(0, 9) < 4;
      wb1_valid = $urandom_range(0, 9) < 4;
      wb0_rd   = pick_rd();
      wb1_rd   = pick_rd();
      wb0_data = $urandom;
      wb1_data = $urandom;
      step();
    end
    rst_n = 1'b1; id_valid = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
